seg7_rx_checker: RTL and testbench
==================================

# seg7_rx_checker

- Input-side receiver for a 7-segment digit stream: samples a segment pattern arriving on `uio_in` (typically another design's `uo_out[6:0]`).
- Synchronizes and debounces the pattern, decodes it back to a BCD digit, and checks that digits advance 0→9 with wrap.
- Reports sequence and encoding errors, and optionally the clock interval between digit changes.
- Sits beside the display counter in the demo top level; used as an on-chip loopback checker for a second board's display.

## Interface
- `STABLE_CYCLES`, default 16: consecutive identical synchronized samples needed to accept a pattern; legal range ≥2.
- `PERIOD_W`, default 24: width of the interval counter and of `period`.
- `clk` in 1: single clock.
- `reset` in 1: reset is synchronous and active-high.
- `segments` in 7: raw pattern, bit0=a … bit6=g, active-high, asynchronous to `clk`.
- `digit` out 4: last accepted valid digit, 0–9.
- `digit_valid` out 1: high while the last accepted pattern was a legal digit.
- `new_digit` out 1: one-cycle pulse on acceptance of a legal digit.
- `seq_error` out 1: one-cycle pulse when an accepted digit is not the previous digit +1 mod 10 while LOCKED.
- `bad_pattern` out 1: one-cycle pulse when an accepted non-blank pattern is not a legal code.
- `error_count` out 8: total `seq_error` + `bad_pattern` events, saturating at 255.
- `locked` out 1: high in state LOCKED.
- `period` out PERIOD_W: clocks between the last two accepted legal digits.

## Operation
- **Legal codes (hex, g..a):**
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - 00 = blank.
  - Anything else is illegal.
- **Synchronizer:** two flops, s1→s2.
- **Debounce:**
  - Registers `cand` and `cnt` (width clog2(STABLE_CYCLES+1)).
  - If s2≠cand: cand←s2, cnt←1.
  - Else if cnt<STABLE_CYCLES: cnt←cnt+1.
  - Acceptance happens on the edge where cnt goes STABLE_CYCLES-1→STABLE_CYCLES, and only if cand≠`acc` (last accepted pattern). On acceptance, acc←cand.
  - A pattern held indefinitely is accepted once.
- **States:** UNLOCKED, LOCKED.
  - Legal digit accepted in UNLOCKED: digit updated, new_digit pulse, digit_valid←1, →LOCKED. No sequence check.
  - Legal digit accepted in LOCKED:
    - If digit ≠ (prev+1) mod 10: seq_error pulse and error_count++.
    - digit is updated regardless (resync). Stays LOCKED.
  - Illegal pattern accepted: bad_pattern pulse, error_count++, digit_valid←0, digit holds, →UNLOCKED.
  - Blank accepted: digit_valid←0, digit holds, →UNLOCKED, no error.
- **Error counter:** seq_error and bad_pattern never coincide. error_count holds at 255.
- **Interval counter `ivl`:**
  - Increments every cycle, saturating at all-ones.
  - Cleared to 1 on each legal-digit acceptance.
  - On a legal acceptance made in LOCKED, period←ivl (the pre-clear value).

## Timing
- **Reset values:** on reset, all outputs are 0; s1, s2, cand, cnt, acc, ivl are 0; state is UNLOCKED. Because acc resets to blank, a blank input after reset is never accepted.
- **Latency:** with pattern P first sampled by s1 at edge 0, acceptance and output update (digit, pulses, locked, period) occur at edge STABLE_CYCLES+1. Example: STABLE_CYCLES=4 → edge 5.
- **Glitch rejection:** any deviation shorter than STABLE_CYCLES samples at s2 is never accepted, and it restarts the count for the pattern that follows it.
- **Pulse width:** all pulses are exactly one cycle and registered.
- **Reset mid-operation:** a reset asserted mid-debounce discards the candidate. That edge's acceptance is suppressed; reset wins.

## Configuration
- `SEG7_RX_PERIOD_EN` defined: ivl counter and `period` logic are present as described.
- Undefined: no ivl register; `period` is tied to 0. All other behaviour is identical.

## Test plan
- Reset, then drive 3F→06→5B, each held 40 cycles, STABLE_CYCLES=16 → new_digit at edge 17 after each change; digit 0,1,2; locked=1 after the first; error_count=0.
- 9 (6F) then 0 (3F) while LOCKED → no seq_error (wrap legal); digit=0.
- 3 (4F) then 5 (6D) → seq_error pulse once, error_count=1, digit=5, still LOCKED.
- 10-cycle glitch 7F inside a steady 07 → no acceptance, no pulses, digit stays 7.
- Pattern 49 (illegal) held → bad_pattern pulse, digit_valid=0, locked=0; then blank → no error; then 06 → new_digit, locked=1, no seq_error.
- With SEG7_RX_PERIOD_EN, digits changing every 100 cycles → period=100 from the second change onward; without the macro, period=0 throughout.

Source files
------------

// File: rtl/seg7_rx_checker_if.sv
// Signal bundle between a 7-segment pattern source and the seg7_rx_checker receiver.
// The source drives segments; the checker drives the decoded digit, status pulses and counters.
interface seg7_rx_checker_if #(
    parameter int PERIOD_W = 24
);
    logic [6:0]          segments;
    logic [3:0]          digit;
    logic                digit_valid;
    logic                new_digit;
    logic                seq_error;
    logic                bad_pattern;
    logic [7:0]          error_count;
    logic                locked;
    logic [PERIOD_W-1:0] period;

    modport master (
        output segments,
        input  digit, digit_valid, new_digit, seq_error, bad_pattern,
        input  error_count, locked, period
    );

    modport slave (
        input  segments,
        output digit, digit_valid, new_digit, seq_error, bad_pattern,
        output error_count, locked, period
    );
endinterface

// File: rtl/seg7_rx_checker.sv
// Loopback checker for a 7-segment digit stream: synchronize, debounce, decode, check 0..9 sequence.
// Define SEG7_RX_PERIOD_EN to build the digit-interval counter; otherwise period reads as zero.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// UNLOCKED | no legal digit since reset, blank or illegal pattern
// LOCKED   | last accepted pattern was a legal digit; sequence is checked
module seg7_rx_checker #(
    parameter int STABLE_CYCLES = 16,
    parameter int PERIOD_W      = 24
) (
    input  logic             clk,
    input  logic             reset,
    seg7_rx_checker_if.slave bus
);
    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_PRE = CNT_W'(STABLE_CYCLES - 1);

    typedef enum logic {UNLOCKED, LOCKED} state_t;

    state_t              state;
    logic [6:0]          s1;
    logic [6:0]          s2;
    logic [6:0]          cand;
    logic [6:0]          acc;
    logic [CNT_W-1:0]    cnt;
    logic [3:0]          digit_r;
    logic                digit_valid_r;
    logic                new_digit_r;
    logic                seq_error_r;
    logic                bad_pattern_r;
    logic [7:0]          error_count_r;
    logic [PERIOD_W-1:0] period_r;

    logic                accept;
    logic [4:0]          dec;
    logic                dec_legal;
    logic [3:0]          dec_value;
    logic [3:0]          next_expected;
    logic                seq_err;
    logic                err_event;

    // Returns {legal, value}; blank and unknown codes both come back as not legal.
    function automatic logic [4:0] decode(input logic [6:0] p);
        case (p)
            7'h3F:   return {1'b1, 4'd0};
            7'h06:   return {1'b1, 4'd1};
            7'h5B:   return {1'b1, 4'd2};
            7'h4F:   return {1'b1, 4'd3};
            7'h66:   return {1'b1, 4'd4};
            7'h6D:   return {1'b1, 4'd5};
            7'h7D:   return {1'b1, 4'd6};
            7'h07:   return {1'b1, 4'd7};
            7'h7F:   return {1'b1, 4'd8};
            7'h6F:   return {1'b1, 4'd9};
            default: return 5'b0;
        endcase
    endfunction

    // Accept on the edge where the stable count reaches STABLE_CYCLES, once per new pattern.
    assign accept        = (s2 == cand) && (cnt == CNT_PRE) && (cand != acc);
    assign dec           = decode(cand);
    assign dec_legal     = dec[4];
    assign dec_value     = dec[3:0];
    assign next_expected = (digit_r == 4'd9) ? 4'd0 : digit_r + 4'd1;
    assign seq_err       = (state == LOCKED) && (dec_value != next_expected);
    assign err_event     = accept && (dec_legal ? seq_err : (cand != 7'd0));

    always_ff @(posedge clk) begin
        if (reset) begin
            s1            <= '0;
            s2            <= '0;
            cand          <= '0;
            cnt           <= '0;
            acc           <= '0;
            state         <= UNLOCKED;
            digit_r       <= '0;
            digit_valid_r <= 1'b0;
            new_digit_r   <= 1'b0;
            seq_error_r   <= 1'b0;
            bad_pattern_r <= 1'b0;
            error_count_r <= '0;
        end else begin
            s1          <= bus.segments;
            s2          <= s1;
            new_digit_r   <= 1'b0;
            seq_error_r   <= 1'b0;
            bad_pattern_r <= 1'b0;

            if (s2 != cand) begin
                cand <= s2;
                cnt  <= CNT_W'(1);
            end else if (cnt < CNT_MAX) begin
                cnt <= cnt + 1'b1;
            end

            if (err_event && (error_count_r != 8'hFF)) begin
                error_count_r <= error_count_r + 8'd1;
            end

            if (accept) begin
                acc <= cand;
                if (dec_legal) begin
                    digit_r       <= dec_value;
                    digit_valid_r <= 1'b1;
                    new_digit_r   <= 1'b1;
                    seq_error_r   <= seq_err;
                    state         <= LOCKED;
                end else begin
                    digit_valid_r <= 1'b0;
                    bad_pattern_r <= (cand != 7'd0);
                    state         <= UNLOCKED;
                end
            end
        end
    end

`ifdef SEG7_RX_PERIOD_EN
    logic [PERIOD_W-1:0] ivl;

    // ivl restarts at 1 so a digit held for N clocks reports period N.
    always_ff @(posedge clk) begin
        if (reset) begin
            ivl      <= '0;
            period_r <= '0;
        end else if (accept && dec_legal) begin
            ivl <= PERIOD_W'(1);
            if (state == LOCKED) begin
                period_r <= ivl;
            end
        end else if (ivl != '1) begin
            ivl <= ivl + 1'b1;
        end
    end
`else
    assign period_r = '0;
`endif

    assign bus.digit       = digit_r;
    assign bus.digit_valid = digit_valid_r;
    assign bus.new_digit   = new_digit_r;
    assign bus.seq_error   = seq_error_r;
    assign bus.bad_pattern = bad_pattern_r;
    assign bus.error_count = error_count_r;
    assign bus.locked      = (state == LOCKED);
    assign bus.period      = period_r;
endmodule

// File: tb/tb_seg7_rx_checker.sv
// Testbench for seg7_rx_checker: per-cycle reference model plus directed table and corner sequences.
module tb_seg7_rx_checker;
    localparam int S  = 16;
    localparam int PW = 24;
`ifdef SEG7_RX_PERIOD_EN
    localparam bit PEN = 1'b1;
`else
    localparam bit PEN = 1'b0;
`endif
    localparam longint IVL_MAX = (longint'(1) << PW) - 1;

    logic clk = 1'b0;
    logic reset = 1'b1;

    seg7_rx_checker_if #(.PERIOD_W(PW)) bus();

    seg7_rx_checker #(.STABLE_CYCLES(S), .PERIOD_W(PW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    int codes [10] = '{'h3F, 'h06, 'h5B, 'h4F, 'h66, 'h6D, 'h7D, 'h07, 'h7F, 'h6F};

    // Reference model: history of sampled patterns; a pattern is accepted when it has been
    // seen at the synchronizer output for exactly S consecutive samples and differs from the last one.
    int     hist [$] = '{0, 0};
    int     m_acc, m_digit, m_err;
    bit     m_locked, m_valid, m_new, m_seq, m_bad;
    longint m_ivl, m_period;

    function automatic int lookup(input int p);
        for (int i = 0; i < 10; i++) if (codes[i] == p) return i;
        return -1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (failures <= 40)
                $display("FAIL %s actual=%0d expected=%0d time=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        int x, run, idx, d;
        longint ivl_pre;
        if (reset) begin
            hist = '{0, 0};
            m_acc = 0; m_digit = 0; m_err = 0;
            m_locked = 0; m_valid = 0; m_new = 0; m_seq = 0; m_bad = 0;
            m_ivl = 0; m_period = 0;
            return;
        end
        hist.push_back(int'(bus.segments));
        if (hist.size() > S + 3) hist.delete(0);
        m_new = 0; m_seq = 0; m_bad = 0;
        idx = hist.size() - 3;
        x = hist[idx];
        run = 0;
        for (int i = idx; i >= 0; i--) begin
            if (hist[i] != x) break;
            run++;
        end
        ivl_pre = m_ivl;
        if (m_ivl < IVL_MAX) m_ivl++;
        if (run == S && x != m_acc) begin
            m_acc = x;
            d = lookup(x);
            if (d >= 0) begin
                if (m_locked) begin
                    m_period = ivl_pre;
                    if (d != (m_digit + 1) % 10) begin
                        m_seq = 1;
                        if (m_err < 255) m_err++;
                    end
                end
                m_digit = d; m_valid = 1; m_new = 1; m_locked = 1; m_ivl = 1;
            end else begin
                m_valid = 0; m_locked = 0;
                if (x != 0) begin
                    m_bad = 1;
                    if (m_err < 255) m_err++;
                end
            end
        end
    endtask

    task automatic compare_all();
        chk("digit", 32'(bus.digit), 32'(m_digit));
        chk("digit_valid", 32'(bus.digit_valid), 32'(m_valid));
        chk("new_digit", 32'(bus.new_digit), 32'(m_new));
        chk("seq_error", 32'(bus.seq_error), 32'(m_seq));
        chk("bad_pattern", 32'(bus.bad_pattern), 32'(m_bad));
        chk("error_count", 32'(bus.error_count), 32'(m_err));
        chk("locked", 32'(bus.locked), 32'(m_locked));
        chk("period", 32'(bus.period), PEN ? 32'(m_period) : 32'd0);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    typedef struct {
        logic [6:0] seg;
        int hold;
        int digit;
        int valid;
        int locked;
        int err;
        int n_new;
        int new_at;
        int n_seq;
        int n_bad;
        int period;
    } vec_t;

    vec_t tbl [22];
    int   n_new, n_seq, n_bad, new_at;
    int   sel, hold, prev_d;

    initial begin
        //          seg    hold dig val lck err new at  seq bad period
        tbl[0]  = '{7'h3F, 40, 0, 1, 1, 0, 1, 17, 0, 0, 0};
        tbl[1]  = '{7'h06, 40, 1, 1, 1, 0, 1, 17, 0, 0, 40};
        tbl[2]  = '{7'h5B, 40, 2, 1, 1, 0, 1, 17, 0, 0, 40};
        tbl[3]  = '{7'h4F, 40, 3, 1, 1, 0, 1, 17, 0, 0, 40};
        tbl[4]  = '{7'h66, 40, 4, 1, 1, 0, 1, 17, 0, 0, 40};
        tbl[5]  = '{7'h6D, 40, 5, 1, 1, 0, 1, 17, 0, 0, 40};
        tbl[6]  = '{7'h7D, 40, 6, 1, 1, 0, 1, 17, 0, 0, 40};
        tbl[7]  = '{7'h07, 40, 7, 1, 1, 0, 1, 17, 0, 0, 40};
        tbl[8]  = '{7'h7F, 40, 8, 1, 1, 0, 1, 17, 0, 0, 40};
        tbl[9]  = '{7'h6F, 40, 9, 1, 1, 0, 1, 17, 0, 0, 40};
        tbl[10] = '{7'h3F, 40, 0, 1, 1, 0, 1, 17, 0, 0, 40};
        tbl[11] = '{7'h06, 40, 1, 1, 1, 0, 1, 17, 0, 0, 40};
        tbl[12] = '{7'h5B, 40, 2, 1, 1, 0, 1, 17, 0, 0, 40};
        tbl[13] = '{7'h4F, 40, 3, 1, 1, 0, 1, 17, 0, 0, 40};
        tbl[14] = '{7'h6D, 40, 5, 1, 1, 1, 1, 17, 1, 0, 40};
        tbl[15] = '{7'h7D, 40, 6, 1, 1, 1, 1, 17, 0, 0, 40};
        tbl[16] = '{7'h07, 40, 7, 1, 1, 1, 1, 17, 0, 0, 40};
        tbl[17] = '{7'h7F, 10, 7, 1, 1, 1, 0, -1, 0, 0, 40};
        tbl[18] = '{7'h07, 40, 7, 1, 1, 1, 0, -1, 0, 0, 40};
        tbl[19] = '{7'h49, 40, 7, 0, 0, 2, 0, -1, 0, 1, 40};
        tbl[20] = '{7'h00, 40, 7, 0, 0, 2, 0, -1, 0, 0, 40};
        tbl[21] = '{7'h06, 40, 1, 1, 1, 2, 1, 17, 0, 0, 40};

        bus.segments = 7'h00;
        reset = 1'b1;
        repeat (3) step();
        chk("rst_digit", 32'(bus.digit), 32'd0);
        chk("rst_locked", 32'(bus.locked), 32'd0);
        chk("rst_error_count", 32'(bus.error_count), 32'd0);
        chk("rst_period", 32'(bus.period), 32'd0);
        reset = 1'b0;
        repeat (30) step();
        chk("blank_after_reset", 32'(bus.digit_valid), 32'd0);

        for (int v = 0; v < 22; v++) begin
            bus.segments = tbl[v].seg;
            n_new = 0; n_seq = 0; n_bad = 0; new_at = -1;
            for (int c = 0; c < tbl[v].hold; c++) begin
                step();
                if (bus.new_digit === 1'b1) begin
                    n_new++;
                    if (new_at < 0) new_at = c;
                end
                if (bus.seq_error === 1'b1) n_seq++;
                if (bus.bad_pattern === 1'b1) n_bad++;
            end
            chk($sformatf("tbl%0d_digit", v), 32'(bus.digit), 32'(tbl[v].digit));
            chk($sformatf("tbl%0d_valid", v), 32'(bus.digit_valid), 32'(tbl[v].valid));
            chk($sformatf("tbl%0d_locked", v), 32'(bus.locked), 32'(tbl[v].locked));
            chk($sformatf("tbl%0d_err", v), 32'(bus.error_count), 32'(tbl[v].err));
            chk($sformatf("tbl%0d_new_cnt", v), 32'(n_new), 32'(tbl[v].n_new));
            chk($sformatf("tbl%0d_new_at", v), 32'(new_at), 32'(tbl[v].new_at));
            chk($sformatf("tbl%0d_seq_cnt", v), 32'(n_seq), 32'(tbl[v].n_seq));
            chk($sformatf("tbl%0d_bad_cnt", v), 32'(n_bad), 32'(tbl[v].n_bad));
            chk($sformatf("tbl%0d_period", v), 32'(bus.period), PEN ? 32'(tbl[v].period) : 32'd0);
        end

        // Digits every 100 clocks: period reads 100 once two consecutive intervals are 100.
        bus.segments = 7'h5B; repeat (100) step();
        bus.segments = 7'h4F; repeat (100) step();
        chk("period_100_a", 32'(bus.period), PEN ? 32'd100 : 32'd0);
        bus.segments = 7'h66; repeat (100) step();
        chk("period_100_b", 32'(bus.period), PEN ? 32'd100 : 32'd0);
        chk("period_run_digit", 32'(bus.digit), 32'd4);

        // Reset in the middle of debouncing a new pattern.
        bus.segments = 7'h6D; repeat (10) step();
        reset = 1'b1; step(); reset = 1'b0;
        chk("mid_rst_digit", 32'(bus.digit), 32'd0);
        chk("mid_rst_locked", 32'(bus.locked), 32'd0);
        n_new = 0;
        for (int c = 0; c < 40; c++) begin
            step();
            if (bus.new_digit === 1'b1) n_new++;
        end
        chk("post_rst_new_cnt", 32'(n_new), 32'd1);
        chk("post_rst_digit", 32'(bus.digit), 32'd5);

        // Reset on the exact acceptance edge wins.
        bus.segments = 7'h7D; repeat (17) step();
        chk("pre_accept_new", 32'(bus.new_digit), 32'd0);
        reset = 1'b1; step(); reset = 1'b0;
        chk("rst_wins_new", 32'(bus.new_digit), 32'd0);
        chk("rst_wins_digit", 32'(bus.digit), 32'd0);
        chk("rst_wins_locked", 32'(bus.locked), 32'd0);

        // Randomized patterns, mostly legal and often in sequence, with occasional resets.
        prev_d = 0;
        for (int r = 0; r < 150; r++) begin
            sel  = $urandom_range(0, 9);
            hold = $urandom_range(1, 40);
            if (sel < 4) begin
                prev_d = (prev_d + 1) % 10;
                bus.segments = 7'(codes[prev_d]);
            end else if (sel < 7) begin
                prev_d = $urandom_range(0, 9);
                bus.segments = 7'(codes[prev_d]);
            end else if (sel == 7) begin
                bus.segments = 7'h00;
            end else begin
                bus.segments = 7'($urandom);
            end
            reset = ($urandom_range(0, 59) == 0);
            for (int c = 0; c < hold; c++) begin
                step();
                reset = 1'b0;
            end
        end

        // Error counter saturation: alternate two illegal codes.
        reset = 1'b1; step(); reset = 1'b0;
        for (int k = 0; k < 135; k++) begin
            bus.segments = 7'h49; repeat (18) step();
            bus.segments = 7'h4A; repeat (18) step();
        end
        chk("err_saturated", 32'(bus.error_count), 32'd255);
        chk("err_sat_locked", 32'(bus.locked), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
